// File: rtl/pmem_rr_if.sv
// pmem_rr_if: I-cache, D-cache and cacheline-adapter signals around the memory arbiter
interface pmem_rr_if #(parameter int ADDR_W = 32, parameter int LINE_W = 256);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              a_read;
  logic              a_write;
  logic [ADDR_W-1:0] a_addr;
  logic [LINE_W-1:0] a_wdata;
  logic [LINE_W-1:0] a_rdata;
  logic              a_resp;
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, a_rdata, a_resp,
    output i_resp, i_rdata, d_resp, d_rdata, a_read, a_write, a_addr, a_wdata
  );
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, a_rdata, a_resp,
    input  i_resp, i_rdata, d_resp, d_rdata, a_read, a_write, a_addr, a_wdata
  );
endinterface

// File: rtl/pmem_rr_arbiter.sv
// pmem_rr_arbiter: round-robin arbiter sharing one cacheline adapter between I and D caches
module pmem_rr_arbiter #(parameter int ADDR_W = 32, parameter int LINE_W = 256) (
  input logic     clk,
  input logic     rst,
  pmem_rr_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;
  state_t state, next;
  logic last_d, i_req, d_req, grant_i, grant_d, serving;
  logic rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  assign i_req   = bus.i_read;
  assign d_req   = bus.d_read | bus.d_write;
  assign serving = (state == SERVE_I) || (state == SERVE_D);
  // contention goes to whoever did not win last; last_d resets to 1 so I wins first
  assign grant_i = (state == IDLE) && i_req && (!d_req || last_d);
  assign grant_d = (state == IDLE) && d_req && !grant_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= next;
  always_comb
    next = grant_i ? SERVE_I :
           grant_d ? SERVE_D :
           (serving && bus.a_resp) ? DONE :
           (state == DONE) ? IDLE : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      last_d  <= 1'b1;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_i) begin
      last_d <= 1'b0;
      rd_q   <= 1'b1;
      wr_q   <= 1'b0;
      addr_q <= bus.i_addr;
    end else if (grant_d) begin
      // a simultaneous read+write is a write-back that must go first
      last_d  <= 1'b1;
      rd_q    <= !bus.d_write;
      wr_q    <= bus.d_write;
      addr_q  <= bus.d_addr;
      wdata_q <= bus.d_wdata;
    end else if (serving && bus.a_resp) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end
  always_comb begin
    bus.i_resp  = (state == SERVE_I) && bus.a_resp;
    bus.d_resp  = (state == SERVE_D) && bus.a_resp;
    bus.a_read  = rd_q;
    bus.a_write = wr_q;
    bus.a_addr  = addr_q;
    bus.a_wdata = wdata_q;
    bus.i_rdata = bus.a_rdata;
    bus.d_rdata = bus.a_rdata;
  end
endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// tb_pmem_rr_arbiter: directed scenarios for the I/D round-robin memory arbiter
module tb_pmem_rr_arbiter;
  logic clk, rst;
  int checks, failures;
  logic [255:0] a5, w1234;
  pmem_rr_if #(.ADDR_W(32), .LINE_W(256)) bus ();
  pmem_rr_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    checks++;
    if (bus.a_read && bus.a_write) begin
      failures++;
      $display("FAIL rd_wr_exclusive a_read=%b a_write=%b required not both 1", bus.a_read, bus.a_write);
    end
  end
  task automatic clear_inputs();
    bus.i_read = 0; bus.i_addr = 0; bus.d_read = 0; bus.d_write = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.a_rdata = 0; bus.a_resp = 0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    #1;
    checks++; if (bus.a_read !== 1'b0) begin failures++; $display("FAIL reset_a_read got=%b exp=0", bus.a_read); end
    checks++; if (bus.a_write !== 1'b0) begin failures++; $display("FAIL reset_a_write got=%b exp=0", bus.a_write); end
    checks++; if (bus.a_addr !== 32'h0) begin failures++; $display("FAIL reset_a_addr got=%h exp=0", bus.a_addr); end
    checks++; if (bus.a_wdata !== 256'h0) begin failures++; $display("FAIL reset_a_wdata got=%h exp=0", bus.a_wdata); end
    checks++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin failures++; $display("FAIL reset_resp got=%b exp=00", {bus.i_resp, bus.d_resp}); end
    @(negedge clk);
    rst = 0;
  endtask
  task automatic test_i_read();
    @(negedge clk);
    bus.i_read = 1; bus.i_addr = 32'h0000_1000;
    #1;
    checks++; if (bus.a_read !== 1'b0) begin failures++; $display("FAIL i_read_latency got=%b exp=0", bus.a_read); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.a_read !== 1'b1) begin failures++; $display("FAIL i_read_a_read cyc=%0d got=%b exp=1", c, bus.a_read); end
      checks++; if (bus.a_addr !== 32'h1000) begin failures++; $display("FAIL i_read_a_addr cyc=%0d got=%h exp=1000", c, bus.a_addr); end
      checks++; if (bus.i_resp !== 1'b0) begin failures++; $display("FAIL i_read_early_resp cyc=%0d got=%b exp=0", c, bus.i_resp); end
    end
    bus.a_resp = 1; bus.a_rdata = a5;
    #1;
    checks++; if (bus.i_resp !== 1'b1) begin failures++; $display("FAIL i_read_resp got=%b exp=1", bus.i_resp); end
    checks++; if (bus.i_rdata !== a5) begin failures++; $display("FAIL i_read_rdata got=%h exp=%h", bus.i_rdata, a5); end
    checks++; if (bus.d_resp !== 1'b0) begin failures++; $display("FAIL i_read_d_resp got=%b exp=0", bus.d_resp); end
    @(negedge clk);
    bus.a_resp = 0; bus.i_read = 0;
    #1;
    checks++; if (bus.a_read !== 1'b0) begin failures++; $display("FAIL i_read_drop got=%b exp=0", bus.a_read); end
    checks++; if (bus.i_resp !== 1'b0) begin failures++; $display("FAIL i_read_resp_pulse got=%b exp=0", bus.i_resp); end
  endtask
  task automatic test_d_write_then_read();
    @(negedge clk);
    bus.d_write = 1; bus.d_addr = 32'h2000; bus.d_wdata = w1234;
    @(negedge clk); #1;
    checks++; if ({bus.a_read, bus.a_write} !== 2'b01) begin failures++; $display("FAIL dwr_op got=%b exp=01", {bus.a_read, bus.a_write}); end
    checks++; if (bus.a_addr !== 32'h2000) begin failures++; $display("FAIL dwr_addr got=%h exp=2000", bus.a_addr); end
    checks++; if (bus.a_wdata !== w1234) begin failures++; $display("FAIL dwr_wdata got=%h exp=%h", bus.a_wdata, w1234); end
    bus.a_resp = 1;
    #1;
    checks++; if ({bus.i_resp, bus.d_resp} !== 2'b01) begin failures++; $display("FAIL dwr_resp got=%b exp=01", {bus.i_resp, bus.d_resp}); end
    @(negedge clk);
    bus.a_resp = 0; bus.d_write = 0; bus.d_read = 1; bus.d_addr = 32'h3000;
    #1;
    checks++; if ({bus.a_read, bus.a_write} !== 2'b00) begin failures++; $display("FAIL dwr_done_gap got=%b exp=00", {bus.a_read, bus.a_write}); end
    @(negedge clk); #1;
    checks++; if ({bus.a_read, bus.a_write} !== 2'b00) begin failures++; $display("FAIL dwr_idle_gap got=%b exp=00", {bus.a_read, bus.a_write}); end
    @(negedge clk); #1;
    checks++; if ({bus.a_read, bus.a_write} !== 2'b10) begin failures++; $display("FAIL drd_op got=%b exp=10", {bus.a_read, bus.a_write}); end
    checks++; if (bus.a_addr !== 32'h3000) begin failures++; $display("FAIL drd_addr got=%h exp=3000", bus.a_addr); end
    bus.a_resp = 1; bus.a_rdata = ~a5;
    #1;
    checks++; if (bus.d_resp !== 1'b1 || bus.d_rdata !== ~a5) begin failures++; $display("FAIL drd_resp got=%b/%h exp=1/%h", bus.d_resp, bus.d_rdata, ~a5); end
    @(negedge clk);
    bus.a_resp = 0; bus.d_read = 0;
  endtask
  task automatic test_fairness();
    logic seen;
    logic exp_i;
    @(negedge clk);
    rst = 1; clear_inputs();
    @(negedge clk);
    rst = 0;
    bus.i_read = 1; bus.i_addr = 32'h1000; bus.d_read = 1; bus.d_addr = 32'h3000;
    for (int k = 0; k < 4; k++) begin
      exp_i = (k % 2 == 0);
      seen = 0;
      for (int c = 0; c < 8 && !seen; c++) begin
        @(negedge clk); #1;
        seen = bus.a_read;
      end
      checks++; if (!seen) begin failures++; $display("FAIL rr_timeout txn=%0d got=0 exp=a_read", k); end
      checks++; if (bus.a_addr !== (exp_i ? 32'h1000 : 32'h3000)) begin failures++; $display("FAIL rr_addr txn=%0d got=%h exp=%h", k, bus.a_addr, exp_i ? 32'h1000 : 32'h3000); end
      bus.a_resp = 1; bus.a_rdata = 256'(k);
      #1;
      checks++; if ({bus.i_resp, bus.d_resp} !== (exp_i ? 2'b10 : 2'b01)) begin failures++; $display("FAIL rr_grant txn=%0d got=%b exp=%b", k, {bus.i_resp, bus.d_resp}, exp_i ? 2'b10 : 2'b01); end
      @(negedge clk);
      bus.a_resp = 0;
    end
    bus.i_read = 0; bus.d_read = 0;
  endtask
  task automatic test_both_rw();
    @(negedge clk);
    bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h4000; bus.d_wdata = a5;
    @(negedge clk); #1;
    checks++; if ({bus.a_read, bus.a_write} !== 2'b01) begin failures++; $display("FAIL rw_both_op got=%b exp=01", {bus.a_read, bus.a_write}); end
    checks++; if (bus.a_addr !== 32'h4000) begin failures++; $display("FAIL rw_both_addr got=%h exp=4000", bus.a_addr); end
    bus.a_resp = 1;
    #1;
    checks++; if (bus.d_resp !== 1'b1) begin failures++; $display("FAIL rw_both_resp got=%b exp=1", bus.d_resp); end
    @(negedge clk);
    bus.a_resp = 0; bus.d_read = 0; bus.d_write = 0;
  endtask
  task automatic test_addr_hold();
    @(negedge clk);
    bus.i_read = 1; bus.i_addr = 32'h1000;
    @(negedge clk); #1;
    checks++; if (bus.a_read !== 1'b1) begin failures++; $display("FAIL hold_a_read got=%b exp=1", bus.a_read); end
    bus.i_addr = 32'h5000;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (bus.a_addr !== 32'h1000) begin failures++; $display("FAIL hold_addr cyc=%0d got=%h exp=1000", c, bus.a_addr); end
    end
    bus.a_resp = 1;
    #1;
    checks++; if ({bus.i_resp, bus.d_resp} !== 2'b10) begin failures++; $display("FAIL hold_resp got=%b exp=10", {bus.i_resp, bus.d_resp}); end
    @(negedge clk);
    bus.a_resp = 0; bus.i_read = 0;
  endtask
  task automatic test_spurious();
    @(negedge clk);
    bus.a_resp = 1;
    #1;
    checks++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin failures++; $display("FAIL spurious_resp got=%b exp=00", {bus.i_resp, bus.d_resp}); end
    @(negedge clk); #1;
    checks++; if ({bus.i_resp, bus.d_resp, bus.a_read, bus.a_write} !== 4'b0000) begin failures++; $display("FAIL spurious_idle got=%b exp=0000", {bus.i_resp, bus.d_resp, bus.a_read, bus.a_write}); end
    bus.a_resp = 0;
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    bus.d_write = 1; bus.d_addr = 32'h2000; bus.d_wdata = w1234;
    @(negedge clk); #1;
    checks++; if (bus.a_write !== 1'b1) begin failures++; $display("FAIL rmid_a_write got=%b exp=1", bus.a_write); end
    bus.a_resp = 1;
    #1;
    checks++; if (bus.d_resp !== 1'b1) begin failures++; $display("FAIL rmid_d_resp got=%b exp=1", bus.d_resp); end
    rst = 1;
    #1;
    checks++; if ({bus.a_write, bus.d_resp} !== 2'b00) begin failures++; $display("FAIL rmid_async got=%b exp=00", {bus.a_write, bus.d_resp}); end
    checks++; if (bus.a_addr !== 32'h0) begin failures++; $display("FAIL rmid_addr got=%h exp=0", bus.a_addr); end
    bus.a_resp = 0; bus.d_write = 0;
    @(negedge clk);
    rst = 0;
    bus.i_read = 1; bus.i_addr = 32'h1000; bus.d_read = 1; bus.d_addr = 32'h3000;
    @(negedge clk); #1;
    checks++; if ({bus.a_read, bus.a_addr} !== {1'b1, 32'h1000}) begin failures++; $display("FAIL rmid_first_grant got=%b/%h exp=1/1000", bus.a_read, bus.a_addr); end
    bus.a_resp = 1;
    #1;
    checks++; if ({bus.i_resp, bus.d_resp} !== 2'b10) begin failures++; $display("FAIL rmid_resp got=%b exp=10", {bus.i_resp, bus.d_resp}); end
    @(negedge clk);
    bus.a_resp = 0; bus.i_read = 0; bus.d_read = 0;
  endtask
  initial begin
    checks = 0; failures = 0;
    a5 = {32{8'hA5}};
    w1234 = {16{16'h1234}};
    rst = 1;
    clear_inputs();
    test_reset();
    test_i_read();
    test_d_write_then_read();
    test_fairness();
    test_both_rw();
    test_addr_hold();
    test_spurious();
    test_reset_mid();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pmem_rr_arbiter.md
Name: pmem_rr_arbiter

Overview:
- Registered, round-robin arbiter that shares the single 256-bit cacheline adapter port between the instruction cache (read-only) and the data cache (read/write-back).
- Sits between the I/D caches' physical-memory ports and the cacheline adapter.
- Latches the winning request for the whole transaction.
- Steers the adapter response back to the winner only.

Parameters:
ADDR_W, 32, address width in bits
LINE_W, 256, cacheline width in bits

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
i_read  in  1  I-cache line read request, held until i_resp
i_addr  in  ADDR_W  I-cache line address
i_resp  out  1  I-cache transaction complete (1-cycle pulse)
i_rdata  out  LINE_W  line returned to I-cache
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache line write-back request, held until d_resp
d_addr  in  ADDR_W  D-cache line address
d_wdata  in  LINE_W  D-cache write-back line
d_resp  out  1  D-cache transaction complete (1-cycle pulse)
d_rdata  out  LINE_W  line returned to D-cache
a_read  out  1  read request to cacheline adapter
a_write  out  1  write request to cacheline adapter
a_addr  out  ADDR_W  address to adapter
a_wdata  out  LINE_W  write line to adapter
a_rdata  in  LINE_W  line from adapter
a_resp  in  1  adapter transaction complete

Behaviour:
- Reset (async, immediate):
  - state=IDLE, last_grant=D.
  - a_read=a_write=0, a_addr=0, a_wdata=0, i_resp=d_resp=0.
- States: IDLE, SERVE_I, SERVE_D, DONE.
- IDLE: sample requests each cycle.
  - Only I pending (i_read): go to SERVE_I.
  - Only D pending (d_read|d_write): go to SERVE_D.
  - Both pending: grant the requester opposite last_grant. First contention after reset goes to I.
  - On the grant edge, latch addr (plus op and wdata for D) into the a_* registers, update last_grant, and set a_read or a_write for the next cycle.
  - If d_read and d_write are both 1: treat as write (write-back first); a_read=0.
- SERVE_I / SERVE_D:
  - a_* outputs held constant from the latched values; live requester inputs are ignored.
  - While a_resp=0: remain in state.
  - On a_resp=1, same cycle (combinational): i_resp (or d_resp)=1 for the winner only; the other resp stays 0.
  - Next edge: a_read/a_write cleared, state goes to DONE.
- DONE: exactly one cycle. All a_* request bits stay 0, no resp asserted, requests not sampled. Lets the cache drop its request. Then go to IDLE.
- i_rdata = d_rdata = a_rdata (pass-through), valid only when the matching resp is 1.
- Latency:
  - Request visible in IDLE at cycle t → a_read/a_write high at t+1.
  - a_resp at cycle N → x_resp at N.
  - Earliest next grant sample at N+2; next a_* request at N+3.
- Fairness: under continuous contention, grants alternate I, D, I, D. No requester waits more than one foreign transaction.
- a_resp while IDLE or DONE: ignored, no resp generated.
- Requester drops its request mid-service (protocol violation): the transaction still completes and x_resp still pulses.
- At most one of a_read/a_write is high at any time. a_read|a_write is high only in SERVE_*.
- Reset mid-transaction: outputs go to reset values immediately and the in-flight transaction is abandoned. The adapter shares rst and is reset with it.

Test Plan:
- Reset, i_read=1, i_addr=0x0000_1000; adapter a_resp after 4 cycles with a_rdata=0xA5..A5 → a_read high from cycle 1, a_addr=0x1000, i_resp one pulse with i_rdata=0xA5..A5, d_resp stays 0, a_read low next cycle.
- d_write=1, d_addr=0x2000, d_wdata=0x1234..; then d_read with d_addr=0x3000 → a_write with a_wdata=0x1234..; d_resp; DONE gap; then a_read at 0x3000. Never a_read&a_write.
- i_read and d_read asserted together from reset, each re-requesting immediately after resp for 4 transactions → grant order I,D,I,D; a_addr alternates between the I and D addresses.
- d_read=d_write=1 simultaneously, d_addr=0x4000 → a_write=1, a_read=0, a_addr=0x4000.
- Change i_addr from 0x1000 to 0x5000 while in SERVE_I → a_addr stays 0x1000 until a_resp.
- Spurious a_resp in IDLE → no i_resp/d_resp. Assert rst mid-SERVE_D → a_write and d_resp fall immediately; after release, the next i_read is granted first.
